pool_unit_arbiter: RTL and testbench

- Shares one avg_pool_unit (2x2 average-pool accumulator) between N_REQ pooling requesters, e.g. per-channel pool engines.
- Grants one whole 2x2 window at a time, round-robin.
- Sequences the unit's reset/enable/operand protocol and returns each averaged result to the requester that owns it.
- Sits between the pool-layer engines and the single shared avg_pool_unit instance.

---
 rtl/pool_ctrl_pkg.sv | 23 ++
 rtl/pool_unit_arbiter_if.sv | 15 +
 rtl/pool_unit_arbiter_rr_pick.sv | 29 ++
 rtl/pool_unit_arbiter.sv | 152 +++++++++++++++
 tb/tb_pool_unit_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pool_ctrl_pkg.sv
// Shared control package for the pool-unit arbiter: FSM states, window layout, helpers.
package pool_ctrl_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int OPS_PER_WIN = 4;

  // Operand slots within one 2x2 window, LSB slot first
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/pool_unit_arbiter_if.sv
// Requester-side bus of the pool-unit arbiter: window requests in, grants/results out.
interface pool_unit_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]          req;
  logic [N_REQ*4*DATA_W-1:0] win;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport master (output req, win, input gnt, rsp_valid, rsp_data, busy);
  modport slave  (input req, win, output gnt, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/pool_unit_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after i_ptr, with wrap-around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_j      = '0;
    // Offset N_REQ lands back on the pointer itself, so the last winner is searched last
    for (int i = 1; i <= N_REQ; i++) begin
      w_j = IDX_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_found && i_req[w_j]) begin
        o_found     = 1'b1;
        o_idx       = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pool_unit_arbiter.sv
// Round-robin sharing of one avg_pool_unit among N_REQ requesters, one 2x2 window at a time.
// Optional macro POOL_ARB_PERF_CNT_EN adds grant_cnt / stall_cnt performance counters.
module pool_unit_arbiter
  import pool_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PU_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  pool_unit_arbiter_if.slave bus,
  output logic              pu_rst,
  output logic              pu_en,
  output logic [DATA_W-1:0] pu_ip,
  input  logic [DATA_W-1:0] pu_avg
`ifdef POOL_ARB_PERF_CNT_EN
  ,
  output logic [N_REQ*16-1:0] grant_cnt,
  output logic [15:0]         stall_cnt
`endif
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAT_W = 4;

  state_e                              r_state;
  logic [IDX_W-1:0]                    r_ptr;
  logic [IDX_W-1:0]                    r_win_idx;
  logic [N_REQ-1:0]                    r_win_oh;
  logic [N_REQ-1:0]                    r_gnt;
  logic [N_REQ-1:0]                    r_rsp_valid;
  logic [DATA_W-1:0]                   r_rsp_data;
  logic                                r_busy;
  logic                                r_pu_rst;
  logic                                r_pu_en;
  logic [DATA_W-1:0]                   r_pu_ip;
  logic [OPS_PER_WIN-1:0][DATA_W-1:0]  r_ops;
  logic [1:0]                          r_k;
  logic [LAT_W-1:0]                    r_lat;

  logic [N_REQ-1:0]                    w_pick_oh;
  logic [IDX_W-1:0]                    w_pick_idx;
  logic                                w_pick_found;
  logic [OPS_PER_WIN*DATA_W-1:0]       w_win_sel;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_win_sel = bus.win[w_pick_idx*OPS_PER_WIN*DATA_W +: OPS_PER_WIN*DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDX_W'(N_REQ-1);
      r_win_idx   <= '0;
      r_win_oh    <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_pu_rst    <= 1'b1;
      r_pu_en     <= 1'b0;
      r_pu_ip     <= '0;
      r_ops       <= '0;
      r_k         <= '0;
      r_lat       <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: if (w_pick_found) begin
          r_ops     <= w_win_sel;
          r_win_idx <= w_pick_idx;
          r_win_oh  <= w_pick_oh;
          r_gnt     <= w_pick_oh;
          r_busy    <= 1'b1;
          r_state   <= CLR;
        end
        CLR: begin
          r_k      <= '0;
          r_pu_rst <= 1'b0;
          r_pu_en  <= 1'b1;
          r_pu_ip  <= r_ops[0];
          r_state  <= FEED;
        end
        FEED: begin
          if (r_k == 2'd3) begin
            r_pu_en <= 1'b0;
            r_lat   <= '0;
            r_state <= WAIT;
          end else begin
            r_k     <= r_k + 2'd1;
            r_pu_ip <= r_ops[r_k + 2'd1];
          end
        end
        WAIT: begin
          // Unit output is valid in the last WAIT cycle; capture it into RESP
          if (r_lat == LAT_W'(PU_LATENCY-1)) begin
            r_rsp_valid <= r_win_oh;
            r_rsp_data  <= pu_avg;
            r_state     <= RESP;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        RESP: begin
          r_ptr    <= r_win_idx;
          r_busy   <= 1'b0;
          r_pu_rst <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;
  assign pu_rst        = r_pu_rst;
  assign pu_en         = r_pu_en;
  assign pu_ip         = r_pu_ip;

`ifdef POOL_ARB_PERF_CNT_EN
  logic [N_REQ-1:0]       w_served;
  logic                   w_stall;
  logic [N_REQ-1:0][15:0] r_gcnt;
  logic [15:0]            r_scnt;

  assign w_served = r_busy ? r_win_oh : '0;
  assign w_stall  = |(bus.req & ~w_served);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt <= '0;
      r_scnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) r_gcnt[i] <= sat_inc16(r_gcnt[i], r_gnt[i]);
      r_scnt <= sat_inc16(r_scnt, w_stall);
    end
  end

  assign grant_cnt = r_gcnt;
  assign stall_cnt = r_scnt;
`endif
endmodule

// File: tb/tb_pool_unit_arbiter.sv
// Scoreboard bench for pool_unit_arbiter with a behavioural avg_pool_unit model.
module tb_pool_unit_arbiter;
  localparam int N_REQ = 4;
  localparam int DW    = 32;
  localparam int L     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pu_rst, pu_en;
  logic [DW-1:0] pu_ip, pu_avg;
`ifdef POOL_ARB_PERF_CNT_EN
  logic [N_REQ*16-1:0] grant_cnt;
  logic [15:0]         stall_cnt;
`endif

  pool_unit_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DW)) bus ();

  pool_unit_arbiter #(.N_REQ(N_REQ), .DATA_W(DW), .PU_LATENCY(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pu_rst (pu_rst),
    .pu_en  (pu_en),
    .pu_ip  (pu_ip),
    .pu_avg (pu_avg)
`ifdef POOL_ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // avg_pool_unit model: accumulate enabled operands, /4, visible L cycles after the last one
  logic signed [DW+1:0] acc;
  logic [DW-1:0]        dly [L-1];
  always @(posedge clk) begin
    if (pu_rst) acc <= '0;
    else if (pu_en) acc <= acc + (DW+2)'(signed'(pu_ip));
    dly[0] <= DW'(acc / 4);
    for (int i = 1; i < L-1; i++) dly[i] <= dly[i-1];
  end
  assign pu_avg = dly[L-2];

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            exp_gnt[$];
  logic [DW-1:0] pu_log[$];
  int n_cmp = 0, n_err = 0, n_gnt = 0, n_rsp = 0, cyc = 0, last_gnt_cyc = 0;
  bit chk_spacing = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] avg4(input int a, input int b, input int c, input int d);
    return DW'((a + b + c + d) / 4);
  endfunction

  task automatic set_win(input int id, input int a, input int b, input int c, input int d);
    bus.win[id*4*DW +: 4*DW] = {DW'(d), DW'(c), DW'(b), DW'(a)};
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int target);
    int b = 0;
    while (n_gnt < target && b < 200) begin tick(); b++; end
    chk("wait_gnt", n_gnt >= target, 1);
  endtask

  task automatic wait_rsp(input int target);
    int b = 0;
    while (n_rsp < target && b < 200) begin tick(); b++; end
    chk("wait_rsp", n_rsp >= target, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t             e;
    int               id;
    logic [N_REQ-1:0] oh;
    if (!rst) begin
      if (bus.gnt != '0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexp", bus.gnt, 0);
        else begin
          id = exp_gnt.pop_front();
          oh = '0; oh[id] = 1'b1;
          chk("gnt_id", bus.gnt, oh);
        end
        if (chk_spacing) chk("gnt_spacing", cyc - last_gnt_cyc, 10);
        last_gnt_cyc = cyc;
        n_gnt++;
      end
      if (pu_en) pu_log.push_back(pu_ip);
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) chk("rsp_unexp", bus.rsp_valid, 0);
        else begin
          e  = sb.pop_front();
          oh = '0; oh[e.id] = 1'b1;
          chk("rsp_id", bus.rsp_valid, oh);
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_lat", cyc - last_gnt_cyc, 8);
        end
        n_rsp++;
      end
    end
  end

  initial begin : drv
    int t_drv, g0, r0;
    int wa[4][4];
    bus.req = '0;
    bus.win = '0;
    rst = 1'b1;
    repeat (4) tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pu_rst", pu_rst, 1);
    chk("rst_pu_en", pu_en, 0);
    chk("rst_pu_ip", pu_ip, 0);
    rst = 1'b0;
    tick();

    // single requester
    set_win(2, 4, 8, 12, 16);
    exp_gnt.push_back(2);
    sb.push_back('{2, avg4(4, 8, 12, 16)});
    pu_log.delete();
    g0 = n_gnt; r0 = n_rsp;
    t_drv = cyc;
    bus.req = 4'b0100;
    wait_gnt(g0 + 1);
    chk("gnt_delay", last_gnt_cyc - t_drv, 1);
    bus.req = '0;
    wait_rsp(r0 + 1);
    chk("pu_en_cycles", pu_log.size(), 4);
    if (pu_log.size() == 4) begin
      chk("pu_ip0", pu_log[0], 4);
      chk("pu_ip1", pu_log[1], 8);
      chk("pu_ip2", pu_log[2], 12);
      chk("pu_ip3", pu_log[3], 16);
    end
    tick(); tick();
    chk("idle_busy1", bus.busy, 0);

    // all four continuously, from a fresh pointer
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    wa = '{'{1, 2, 3, 6}, '{100, 200, 300, 400}, '{-1, -2, -3, -6}, '{7, 7, 7, 7}};
    for (int i = 0; i < 4; i++) set_win(i, wa[i][0], wa[i][1], wa[i][2], wa[i][3]);
    for (int k = 0; k < 8; k++) begin
      exp_gnt.push_back(k % 4);
      sb.push_back('{k % 4, avg4(wa[k%4][0], wa[k%4][1], wa[k%4][2], wa[k%4][3])});
    end
    g0 = n_gnt; r0 = n_rsp;
    bus.req = 4'hF;
    wait_gnt(g0 + 1);
    chk_spacing = 1'b1;
    wait_rsp(r0 + 8);
    bus.req = '0;
    chk_spacing = 1'b0;
    tick();
`ifdef POOL_ARB_PERF_CNT_EN
    for (int i = 0; i < N_REQ; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 2);
    chk("stall_nz", stall_cnt != 16'd0, 1);
`endif

    // negative operands
    set_win(0, -8, -4, 4, -12);
    exp_gnt.push_back(0);
    sb.push_back('{0, avg4(-8, -4, 4, -12)});
    g0 = n_gnt; r0 = n_rsp;
    bus.req = 4'b0001;
    wait_gnt(g0 + 1);
    bus.req = '0;
    wait_rsp(r0 + 1);
    tick(); tick();
    chk("neg_hold", bus.rsp_data, 32'hFFFF_FFFB);

    // reset in the 2nd FEED cycle of requester 1, then served again
    set_win(1, 20, 30, 40, 50);
    exp_gnt.push_back(1);
    exp_gnt.push_back(1);
    sb.push_back('{1, avg4(20, 30, 40, 50)});
    g0 = n_gnt; r0 = n_rsp;
    bus.req = 4'b0010;
    wait_gnt(g0 + 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_pu_rst", pu_rst, 1);
    chk("mid_rst_pu_en", pu_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    wait_gnt(g0 + 2);
    bus.req = '0;
    wait_rsp(r0 + 1);

    // req[3] pulse during requester 0's WAIT is never served
    set_win(0, 1, 1, 1, 1);
    set_win(3, 9, 9, 9, 9);
    exp_gnt.push_back(0);
    sb.push_back('{0, avg4(1, 1, 1, 1)});
    g0 = n_gnt; r0 = n_rsp;
    bus.req = 4'b0001;
    wait_gnt(g0 + 1);
    bus.req = '0;
    repeat (5) tick();
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    wait_rsp(r0 + 1);
    tick(); tick();
    chk("idle_busy2", bus.busy, 0);
    repeat (15) tick();
    chk("no_extra_gnt", n_gnt, g0 + 1);
    chk("gnt_q_empty", exp_gnt.size(), 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
